// File: rtl/m_divider.sv
// 32-bit restoring divider, signed/unsigned, one quotient bit per cycle.
module m_divider (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_by_zero
);

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 6;
    localparam int unsigned PW   = W + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_quot;
    logic [W-1:0]    r_div;
    logic [PW-1:0]   r_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_q_out;
    logic [W-1:0]    r_r_out;
    logic            r_dbz;

    logic            w_start;
    logic            w_zero;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [PW:0]     w_shift;
    logic [PW:0]     w_sub;
    logic            w_ge;
    logic [PW-1:0]   w_rem_nxt;
    logic [W-1:0]    w_q_nxt;
    logic [W-1:0]    w_rem_lo;
    logic [W-1:0]    w_q_fix;
    logic [W-1:0]    w_r_fix;

    // Operand capture: start accepted outside RUN, magnitudes for signed mode
    always_comb begin
        w_start = i_start && (r_state != S_RUN);
        w_zero  = (i_divisor == '0);
        w_a_neg = i_signed & i_dividend[W-1];
        w_b_neg = i_signed & i_divisor[W-1];
        w_a_mag = w_a_neg ? W'(~i_dividend + W'(1)) : i_dividend;
        w_b_mag = w_b_neg ? W'(~i_divisor  + W'(1)) : i_divisor;
    end

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        w_shift   = {r_rem, r_quot[W-1]};
        w_ge      = (w_shift >= {2'b00, r_div});
        w_sub     = w_shift - {2'b00, r_div};
        w_rem_nxt = w_ge ? PW'(w_sub) : PW'(w_shift);
        w_q_nxt   = {r_quot[W-2:0], w_ge};
        w_rem_lo  = W'(w_rem_nxt);
        w_q_fix   = r_neg_q ? W'(~w_q_nxt  + W'(1)) : w_q_nxt;
        w_r_fix   = r_neg_r ? W'(~w_rem_lo + W'(1)) : w_rem_lo;
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = w_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                if (i_start) w_next = w_zero ? S_DONE : S_RUN;
                else         w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered status flags track the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
        end
    end

    // Datapath: capture, iterate, and load results on DONE entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_quot  <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dbz   <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_quot  <= w_a_mag;
            r_div   <= w_b_mag;
            r_rem   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dbz   <= 1'b0;
            if (w_zero) begin
                r_q_out <= '1;
                r_r_out <= i_dividend;
                r_dbz   <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt + CW'(1);
            r_quot <= w_q_nxt;
            r_rem  <= w_rem_nxt;
            if (r_cnt == LAST) begin
                r_q_out <= w_q_fix;
                r_r_out <= w_r_fix;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_q_out;
    assign o_remainder   = r_r_out;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_m_divider.sv
// Directed-vector bench for m_divider.
module tb_m_divider;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_div_by_zero;

    int total = 0;
    int bad   = 0;

    m_divider dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_signed      (i_signed),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse start on the next edge; leaves the bench #1 after that edge
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Count cycles after the start edge until o_done, bounded
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!o_done && lat < 40) begin
            if (o_busy) busy_cnt++;
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] q,
                                input logic [31:0] r, input logic dbz);
        check({name, ".done"}, 32'(o_done), 32'd1);
        check({name, ".q"}, o_quotient, q);
        check({name, ".r"}, o_remainder, r);
        check({name, ".dbz"}, 32'(o_div_by_zero), 32'(dbz));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bc;
        string nm;
        nm = $sformatf("vec%0d", idx);
        launch(v.sgn, v.a, v.b);
        wait_done(lat, bc);
        check({nm, ".lat"}, 32'(lat), v.dbz ? 32'd0 : 32'd32);
        check({nm, ".busy"}, 32'(bc), v.dbz ? 32'd0 : 32'd32);
        check_result(nm, v.q, v.r, v.dbz);
    endtask

    initial begin
        int lat;
        int bc;
        bit saw_done;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
        vecs[3]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
        vecs[4]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[7]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[8]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        vecs[9]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
        vecs[12] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};

        // Reset state
        #12;
        check("rst.busy", 32'(o_busy), 32'd0);
        check("rst.done", 32'(o_done), 32'd0);
        check("rst.q", o_quotient, 32'd0);
        check("rst.r", o_remainder, 32'd0);
        check("rst.dbz", 32'(o_div_by_zero), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Start pulsed mid-RUN with new operands is ignored
        launch(1'b0, 32'd1000, 32'd10);
        repeat (5) @(posedge i_clk);
        #1;
        i_start = 1'b1; i_dividend = 32'd7; i_divisor = 32'd0; i_signed = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        check("midrun.busy", 32'(o_busy), 32'd1);
        wait_done(lat, bc);
        check("midrun.lat", 32'(lat + 6), 32'd32);
        check_result("midrun", 32'd100, 32'd0, 1'b0);

        // Start during DONE: back-to-back division
        launch(1'b0, 32'd100, 32'd7);
        wait_done(lat, bc);
        check("b2b1.lat", 32'(lat), 32'd32);
        check_result("b2b1", 32'd14, 32'd2, 1'b0);
        i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd50; i_divisor = 32'd5;
        check("b2b.busy_in_done", 32'(o_busy), 32'd0);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        check("b2b.busy_next", 32'(o_busy), 32'd1);
        check("b2b.done_next", 32'(o_done), 32'd0);
        wait_done(lat, bc);
        check("b2b2.lat", 32'(lat), 32'd32);
        check_result("b2b2", 32'd10, 32'd0, 1'b0);

        // Divide-by-zero flag cleared by next valid division
        launch(1'b0, 32'h12345678, 32'd0);
        check_result("dbz", 32'hFFFFFFFF, 32'h12345678, 1'b1);
        launch(1'b0, 32'd21, 32'd4);
        check("dbz.clr_busy", 32'(o_busy), 32'd1);
        wait_done(lat, bc);
        check_result("dbzclr", 32'd5, 32'd1, 1'b0);

        // Asynchronous reset at RUN cycle 10 aborts with no o_done
        launch(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(o_busy), 32'd0);
        check("arst.done", 32'(o_done), 32'd0);
        check("arst.q", o_quotient, 32'd0);
        check("arst.r", o_remainder, 32'd0);
        check("arst.dbz", 32'(o_div_by_zero), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        check("arst.no_done", 32'(saw_done), 32'd0);
        launch(1'b0, 32'd9, 32'd3);
        wait_done(lat, bc);
        check("post.lat", 32'(lat), 32'd32);
        check_result("post", 32'd3, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
